// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the 5-stage MIPS core.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int GPR_W  = 5;
   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LB      = 3'd1,
      LBU     = 3'd2,
      LH      = 3'd3,
      LHU     = 3'd4,
      LW      = 3'd5,
      LWL     = 3'd6,
      LWR     = 3'd7
   } load_op_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Little-endian load byte/halfword/word extraction and LWL/LWR
//                merge with the old rt value.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
   import cpu_pkg::*;
(
   input  load_op_t          load_op,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] word,
   input  logic [DATA_W-1:0] rt_val,
   output logic [DATA_W-1:0] aligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (addr_lo)
         2'd0:    w_byte = word[7:0];
         2'd1:    w_byte = word[15:8];
         2'd2:    w_byte = word[23:16];
         default: w_byte = word[31:24];
      endcase
   end

   // addr_lo[0] is ignored for halfwords; misalignment traps before MEM.
   assign w_half = addr_lo[1] ? word[31:16] : word[15:0];

   always_comb begin
      aligned = word;
      case (load_op)
         LB:  aligned = {{24{w_byte[7]}}, w_byte};
         LBU: aligned = {24'h000000, w_byte};
         LH:  aligned = {{16{w_half[15]}}, w_half};
         LHU: aligned = {16'h0000, w_half};
         LWL: begin
            case (addr_lo)
               2'd0:    aligned = {word[7:0],  rt_val[23:0]};
               2'd1:    aligned = {word[15:0], rt_val[15:0]};
               2'd2:    aligned = {word[23:0], rt_val[7:0]};
               default: aligned = word;
            endcase
         end
         LWR: begin
            case (addr_lo)
               2'd0:    aligned = word;
               2'd1:    aligned = {rt_val[31:24], word[31:8]};
               2'd2:    aligned = {rt_val[31:16], word[31:16]};
               default: aligned = {rt_val[31:8],  word[31:24]};
            endcase
         end
         default: aligned = word;
      endcase
   end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : MEM->WB pipeline stage: holds the instruction until its load
//                data returns, aligns it, and drives the regfile write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
   parameter int DATA_W   = 32,
   parameter bit TRACE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_valid,
   output logic              wb_allowin,
   input  logic [31:0]       mem_pc,
   input  logic              mem_wren,
   input  logic [4:0]        mem_dest,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [2:0]        mem_load_op,
   input  logic [1:0]        mem_addr_lo,
   input  logic [DATA_W-1:0] mem_rt_val,
   input  logic              data_rdata_valid,
   input  logic [DATA_W-1:0] data_rdata,
   input  logic              flush,
   output logic              wb_regfile_wren,
   output logic [4:0]        wb_regfile_wt_addr,
   output logic [DATA_W-1:0] wb_regfile_wt_val,
   output logic [31:0]       debug_wb_pc,
   output logic [3:0]        debug_wb_rf_wen,
   output logic [4:0]        debug_wb_rf_wnum,
   output logic [DATA_W-1:0] debug_wb_rf_wdata
);
   import cpu_pkg::*;

   logic              r_wb_valid;
   logic              r_rdata_got;
   logic              r_drop_pending;
   logic [31:0]       r_pc;
   logic              r_wren;
   logic [GPR_W-1:0]  r_dest;
   logic [DATA_W-1:0] r_result;
   load_op_t          r_load_op;
   logic [1:0]        r_addr_lo;
   logic [DATA_W-1:0] r_rt_val;
   logic [DATA_W-1:0] r_rdata_q;

   logic              w_is_load;
   logic              w_rdata_live;
   logic              w_ready_go;
   logic              w_retire;
   logic              w_capture;
   logic              w_hold;
   logic              w_drop_set;
   logic [DATA_W-1:0] w_word;
   logic [DATA_W-1:0] w_aligned;

   // A pulse arriving while a flushed load is still owed belongs to that
   // load, never to whatever occupies WB now.
   assign w_rdata_live = data_rdata_valid && !r_drop_pending;
   assign w_is_load    = (r_load_op != LD_NONE);
   assign w_ready_go   = !w_is_load || r_rdata_got || w_rdata_live;
   assign wb_allowin   = !r_wb_valid || w_ready_go;
   assign w_retire     = r_wb_valid && w_ready_go;
   assign w_capture    = mem_valid && wb_allowin && !flush;
   assign w_hold       = w_rdata_live && r_wb_valid && w_is_load && !r_rdata_got && !w_capture;
   assign w_drop_set   = flush && r_wb_valid && w_is_load && !r_rdata_got && !w_rdata_live;
   assign w_word       = r_rdata_got ? r_rdata_q : data_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wb_valid     <= 1'b0;
         r_rdata_got    <= 1'b0;
         r_drop_pending <= 1'b0;
         r_pc           <= '0;
         r_wren         <= 1'b0;
         r_dest         <= '0;
         r_result       <= '0;
         r_load_op      <= LD_NONE;
         r_addr_lo      <= '0;
         r_rt_val       <= '0;
         r_rdata_q      <= '0;
      end else begin
         if (flush)
            r_wb_valid <= 1'b0;
         else if (w_capture)
            r_wb_valid <= 1'b1;
         else if (w_retire)
            r_wb_valid <= 1'b0;

         if (w_capture) begin
            r_pc      <= mem_pc;
            r_wren    <= mem_wren;
            r_dest    <= mem_dest;
            r_result  <= mem_result;
            r_load_op <= load_op_t'(mem_load_op);
            r_addr_lo <= mem_addr_lo;
            r_rt_val  <= mem_rt_val;
         end

         if (flush || w_retire)
            r_rdata_got <= 1'b0;
         else if (w_hold)
            r_rdata_got <= 1'b1;

         if (w_hold)
            r_rdata_q <= data_rdata;

         r_drop_pending <= w_drop_set || (r_drop_pending && !data_rdata_valid);
      end
   end

   load_align u_load_align (
      .load_op (r_load_op),
      .addr_lo (r_addr_lo),
      .word    (w_word),
      .rt_val  (r_rt_val),
      .aligned (w_aligned)
   );

   // A load still waiting on data never asserts the write, so the regfile
   // bypass cannot forward a stale value.
   assign wb_regfile_wren    = w_retire && r_wren && (r_dest != '0);
   assign wb_regfile_wt_addr = r_dest;
   assign wb_regfile_wt_val  = w_is_load ? w_aligned : r_result;

   generate
      if (TRACE_EN) begin : g_trace_on
         assign debug_wb_pc       = r_wb_valid ? r_pc : 32'h0;
         assign debug_wb_rf_wen   = wb_regfile_wren ? 4'hf : 4'h0;
         assign debug_wb_rf_wnum  = wb_regfile_wt_addr;
         assign debug_wb_rf_wdata = wb_regfile_wt_val;
      end else begin : g_trace_off
         assign debug_wb_pc       = 32'h0;
         assign debug_wb_rf_wen   = 4'h0;
         assign debug_wb_rf_wnum  = 5'h0;
         assign debug_wb_rf_wdata = '0;
      end
   endgenerate

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Directed vector bench for the MEM->WB stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_LB   = 3'd1;
   localparam logic [2:0] OP_LBU  = 3'd2;
   localparam logic [2:0] OP_LH   = 3'd3;
   localparam logic [2:0] OP_LHU  = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_LWL  = 3'd6;
   localparam logic [2:0] OP_LWR  = 3'd7;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid;
   logic        wb_allowin;
   logic [31:0] mem_pc;
   logic        mem_wren;
   logic [4:0]  mem_dest;
   logic [31:0] mem_result;
   logic [2:0]  mem_load_op;
   logic [1:0]  mem_addr_lo;
   logic [31:0] mem_rt_val;
   logic        data_rdata_valid;
   logic [31:0] data_rdata;
   logic        flush;
   logic        wb_regfile_wren;
   logic [4:0]  wb_regfile_wt_addr;
   logic [31:0] wb_regfile_wt_val;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_wb_stage #(.DATA_W(32), .TRACE_EN(1'b1)) dut (
      .clk                (clk),
      .resetn             (resetn),
      .mem_valid          (mem_valid),
      .wb_allowin         (wb_allowin),
      .mem_pc             (mem_pc),
      .mem_wren           (mem_wren),
      .mem_dest           (mem_dest),
      .mem_result         (mem_result),
      .mem_load_op        (mem_load_op),
      .mem_addr_lo        (mem_addr_lo),
      .mem_rt_val         (mem_rt_val),
      .data_rdata_valid   (data_rdata_valid),
      .data_rdata         (data_rdata),
      .flush              (flush),
      .wb_regfile_wren    (wb_regfile_wren),
      .wb_regfile_wt_addr (wb_regfile_wt_addr),
      .wb_regfile_wt_val  (wb_regfile_wt_val),
      .debug_wb_pc        (debug_wb_pc),
      .debug_wb_rf_wen    (debug_wb_rf_wen),
      .debug_wb_rf_wnum   (debug_wb_rf_wnum),
      .debug_wb_rf_wdata  (debug_wb_rf_wdata)
   );

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic        wren;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [1:0]  lo;
      logic [31:0] rt;
      logic [31:0] rdata;
      logic        exp_wen;
      logic [31:0] exp_val;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic v, input logic [31:0] pc, input logic [2:0] op,
                            input logic wr, input logic [4:0] d, input logic [31:0] res,
                            input logic [1:0] lo, input logic [31:0] rt);
      mem_valid   = v;
      mem_pc      = pc;
      mem_load_op = op;
      mem_wren    = wr;
      mem_dest    = d;
      mem_result  = res;
      mem_addr_lo = lo;
      mem_rt_val  = rt;
   endtask

   task automatic chk_write(input string tag, input logic wen, input logic [4:0] addr,
                            input logic [31:0] val);
      chk({tag, ".wren"}, 32'(wb_regfile_wren), 32'(wen));
      chk({tag, ".debug_wen"}, 32'(debug_wb_rf_wen), wen ? 32'hf : 32'h0);
      if (wen) begin
         chk({tag, ".addr"}, 32'(wb_regfile_wt_addr), 32'(addr));
         chk({tag, ".val"}, wb_regfile_wt_val, val);
         chk({tag, ".debug_wdata"}, debug_wb_rf_wdata, val);
         chk({tag, ".debug_wnum"}, 32'(debug_wb_rf_wnum), 32'(addr));
      end
   endtask

   initial begin
      vecs[0]  = '{"addu_r3", OP_NONE, 1'b1, 5'd3, 32'h1234_5678, 2'd0, 32'h0, 32'h0, 1'b1, 32'h1234_5678};
      vecs[1]  = '{"addu_r0", OP_NONE, 1'b1, 5'd0, 32'hCAFE_0001, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0};
      vecs[2]  = '{"nowren",  OP_NONE, 1'b0, 5'd9, 32'h0000_0009, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0};
      vecs[3]  = '{"lb_a3",   OP_LB,   1'b1, 5'd4, 32'h0, 2'd3, 32'h0, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80};
      vecs[4]  = '{"lbu_a3",  OP_LBU,  1'b1, 5'd4, 32'h0, 2'd3, 32'h0, 32'h80FF_0000, 1'b1, 32'h0000_0080};
      vecs[5]  = '{"lb_a1",   OP_LB,   1'b1, 5'd6, 32'h0, 2'd1, 32'h0, 32'h0000_7F00, 1'b1, 32'h0000_007F};
      vecs[6]  = '{"lh_a2",   OP_LH,   1'b1, 5'd7, 32'h0, 2'd2, 32'h0, 32'h8001_1234, 1'b1, 32'hFFFF_8001};
      vecs[7]  = '{"lhu_a0",  OP_LHU,  1'b1, 5'd7, 32'h0, 2'd0, 32'h0, 32'h8001_F234, 1'b1, 32'h0000_F234};
      vecs[8]  = '{"lw",      OP_LW,   1'b1, 5'd31, 32'h0, 2'd0, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
      vecs[9]  = '{"lwl_a1",  OP_LWL,  1'b1, 5'd2, 32'h0, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'h3344_CCDD};
      vecs[10] = '{"lwl_a0",  OP_LWL,  1'b1, 5'd2, 32'h0, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'h44BB_CCDD};
      vecs[11] = '{"lwr_a2",  OP_LWR,  1'b1, 5'd2, 32'h0, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'hAABB_1122};
      vecs[12] = '{"lwr_a3",  OP_LWR,  1'b1, 5'd2, 32'h0, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'hAABB_CC11};
      vecs[13] = '{"lwr_a1",  OP_LWR,  1'b1, 5'd2, 32'h0, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'hAA11_2233};

      resetn = 1'b0;
      flush = 1'b0;
      data_rdata_valid = 1'b0;
      data_rdata = 32'h0;
      set_instr(1'b0, 32'h0, OP_NONE, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
      #12;
      chk("reset.allowin", 32'(wb_allowin), 32'h1);
      chk("reset.wren", 32'(wb_regfile_wren), 32'h0);
      chk("reset.debug_pc", debug_wb_pc, 32'h0);
      chk("reset.wt_val", wb_regfile_wt_val, 32'h0);
      resetn = 1'b1;
      tick();

      // Table: capture one instruction, then present its data one cycle later.
      for (int i = 0; i < 14; i++) begin
         set_instr(1'b1, 32'h1000 + 32'(i) * 4, vecs[i].op, vecs[i].wren, vecs[i].dest,
                   vecs[i].result, vecs[i].lo, vecs[i].rt);
         tick();
         set_instr(1'b0, 32'h0, OP_NONE, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
         data_rdata_valid = (vecs[i].op != OP_NONE);
         data_rdata = vecs[i].rdata;
         #2;
         chk_write(vecs[i].name, vecs[i].exp_wen, vecs[i].dest, vecs[i].exp_val);
         chk({vecs[i].name, ".debug_pc"}, debug_wb_pc, 32'h1000 + 32'(i) * 4);
         chk({vecs[i].name, ".allowin"}, 32'(wb_allowin), 32'h1);
         tick();
         data_rdata_valid = 1'b0;
         data_rdata = 32'h0;
      end
      #2;
      chk("idle.debug_pc", debug_wb_pc, 32'h0);
      chk("idle.wren", 32'(wb_regfile_wren), 32'h0);

      // Late LW with MEM holding the next instruction.
      set_instr(1'b1, 32'h2000, OP_LW, 1'b1, 5'd10, 32'h0, 2'd0, 32'h0);
      tick();
      set_instr(1'b1, 32'h2004, OP_NONE, 1'b1, 5'd5, 32'h0000_0055, 2'd0, 32'h0);
      for (int c = 0; c < 2; c++) begin
         #2;
         chk("late.stall_allowin", 32'(wb_allowin), 32'h0);
         chk("late.stall_wren", 32'(wb_regfile_wren), 32'h0);
         chk("late.stall_pc", debug_wb_pc, 32'h2000);
         tick();
      end
      data_rdata_valid = 1'b1;
      data_rdata = 32'h0BAD_F00D;
      #2;
      chk_write("late.retire", 1'b1, 5'd10, 32'h0BAD_F00D);
      chk("late.retire_allowin", 32'(wb_allowin), 32'h1);
      tick();
      data_rdata_valid = 1'b0;
      set_instr(1'b0, 32'h0, OP_NONE, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
      #2;
      chk_write("late.next", 1'b1, 5'd5, 32'h0000_0055);
      chk("late.next_pc", debug_wb_pc, 32'h2004);
      tick();

      // Flush a waiting load; its late pulse must not feed the next load.
      set_instr(1'b1, 32'h3000, OP_LW, 1'b1, 5'd7, 32'h0, 2'd0, 32'h0);
      tick();
      set_instr(1'b0, 32'h0, OP_NONE, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
      flush = 1'b1;
      #2;
      chk("flush.wren", 32'(wb_regfile_wren), 32'h0);
      tick();
      flush = 1'b0;
      set_instr(1'b1, 32'h3004, OP_LW, 1'b1, 5'd8, 32'h0, 2'd0, 32'h0);
      #2;
      chk("flush.after_pc", debug_wb_pc, 32'h0);
      chk("flush.after_allowin", 32'(wb_allowin), 32'h1);
      tick();
      set_instr(1'b0, 32'h0, OP_NONE, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
      data_rdata_valid = 1'b1;
      data_rdata = 32'hBAD0_BAD0;
      #2;
      chk("flush.stale_wren", 32'(wb_regfile_wren), 32'h0);
      chk("flush.stale_allowin", 32'(wb_allowin), 32'h0);
      tick();
      data_rdata = 32'h600D_600D;
      #2;
      chk_write("flush.own_data", 1'b1, 5'd8, 32'h600D_600D);
      tick();
      data_rdata_valid = 1'b0;
      #2;
      chk("flush.done_pc", debug_wb_pc, 32'h0);
      chk("flush.done_allowin", 32'(wb_allowin), 32'h1);
      tick();

      // Asynchronous reset while a load waits.
      set_instr(1'b1, 32'h4000, OP_LW, 1'b1, 5'd9, 32'h0, 2'd0, 32'h0);
      tick();
      set_instr(1'b0, 32'h0, OP_NONE, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
      #2;
      chk("rst.pre_allowin", 32'(wb_allowin), 32'h0);
      chk("rst.pre_pc", debug_wb_pc, 32'h4000);
      resetn = 1'b0;
      #1;
      chk("rst.allowin", 32'(wb_allowin), 32'h1);
      chk("rst.pc", debug_wb_pc, 32'h0);
      chk("rst.wren", 32'(wb_regfile_wren), 32'h0);
      chk("rst.wnum", 32'(debug_wb_rf_wnum), 32'h0);
      chk("rst.wt_addr", 32'(wb_regfile_wt_addr), 32'h0);
      #4;
      resetn = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_mem_wb_stage
`default_nettype wire
